// File: rtl/serial_comp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state encoding and the {aeb, agb, alb} one-hot result codes.
package serial_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CMP  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [2:0] RES_EQ = 3'b100;
    localparam logic [2:0] RES_GT = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    function automatic logic [2:0] encode_result(input logic gt, input logic lt);
        if (gt)
            return RES_GT;
        else if (lt)
            return RES_LT;
        else
            return RES_EQ;
    endfunction

endpackage

// File: rtl/serial_mag_comp_cell.sv
// Combinational 1-bit comparator cell: a, b -> aeb/agb/alb.
module bit_cmp_cell (
    input  logic a,
    input  logic b,
    output logic aeb,
    output logic agb,
    output logic alb
);

    assign aeb = ~(a ^ b);
    assign agb = a & ~b;
    assign alb = ~a & b;

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial MSB-first magnitude comparator with registered eq/gt/lt verdict.
// Optional early exit on first differing bit: SERIAL_COMP_EARLY_EXIT_EN.
module serial_mag_comp
    import serial_comp_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             busy,
    output logic             done,
    output logic             aeb,
    output logic             agb,
    output logic             alb,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             gt_r, lt_r;
    logic             gt_nxt, lt_nxt;
    logic             cell_aeb, cell_agb, cell_alb;

    bit_cmp_cell u_cell (
        .a   (a_bit),
        .b   (b_bit),
        .aeb (cell_aeb),
        .agb (cell_agb),
        .alb (cell_alb)
    );

    assign cnt_inc = bit_cnt + CNT_W'(1);
    assign busy    = (state == CMP);
    assign done    = (state == DONE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        gt_nxt    = gt_r;
        lt_nxt    = lt_r;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CMP;
                    cnt_nxt   = '0;
                    gt_nxt    = 1'b0;
                    lt_nxt    = 1'b0;
                end
            end
            CMP: begin
                if (start) begin
                    cnt_nxt = '0;
                    gt_nxt  = 1'b0;
                    lt_nxt  = 1'b0;
                end else if (bit_valid) begin
                    cnt_nxt = cnt_inc;
                    // the first differing bit decides; flags freeze after it
                    if (!gt_r && !lt_r && !cell_aeb) begin
                        gt_nxt = cell_agb;
                        lt_nxt = cell_alb;
                    end
                    if (cnt_inc == CNT_FULL)
                        state_nxt = DONE;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
                    if (!cell_aeb)
                        state_nxt = DONE;
`else
`endif
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = CMP;
                    cnt_nxt   = '0;
                    gt_nxt    = 1'b0;
                    lt_nxt    = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
            aeb     <= 1'b0;
            agb     <= 1'b0;
            alb     <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
            gt_r    <= gt_nxt;
            lt_r    <= lt_nxt;
            // verdict lands together with the done pulse
            if (state_nxt == DONE)
                {aeb, agb, alb} <= encode_result(gt_nxt, lt_nxt);
        end
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp: directed plan plus random operands.
module tb_serial_mag_comp;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          bit_valid;
    logic          a_bit;
    logic          b_bit;
    logic          busy;
    logic          done;
    logic          aeb;
    logic          agb;
    logic          alb;
    logic [CW-1:0] bit_cnt;

    int            checks = 0;
    int            failures = 0;
    logic [2:0]    prev_v;

    serial_mag_comp #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .done      (done),
        .aeb       (aeb),
        .agb       (agb),
        .alb       (alb),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: verdict from integer compare; deciding position from a^b.
    function automatic logic [2:0] ref_verdict(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        if (a == b)
            return 3'b100;
        else if (a > b)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    function automatic int ref_bits(input logic [W-1:0] a,
                                    input logic [W-1:0] b);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        logic [W-1:0] x;
        x = a ^ b;
        for (int i = W - 1; i >= 0; i--)
            if (x[i])
                return W - i;
        return W;
`else
        return W;
`endif
    endfunction

    // Starts a comparison (start also drives a junk valid bit that must be
    // ignored), streams bits with an optional bubble run, and returns with
    // the DUT in its DONE cycle.
    task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int bub_at, input int bub_len);
        int         k;
        int         acc;
        logic [2:0] v;
        v = ref_verdict(a, b);
        k = ref_bits(a, b);
        start     = 1'b1;
        bit_valid = 1'b1;
        a_bit     = 1'($urandom);
        b_bit     = 1'($urandom);
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("cnt_after_start", bit_cnt, 0);
        chk("verdict_hold_start", {aeb, agb, alb}, prev_v);
        acc = 0;
        while (acc < k) begin
            a_bit     = a[W-1-acc];
            b_bit     = b[W-1-acc];
            bit_valid = 1'b1;
            step();
            acc++;
            if (acc < k) begin
                chk("done_early", done, 0);
                chk("cnt_bit", bit_cnt, acc);
                chk("verdict_hold_bit", {aeb, agb, alb}, prev_v);
                if (acc == bub_at) begin
                    for (int j = 0; j < bub_len; j++) begin
                        bit_valid = 1'b0;
                        a_bit     = 1'($urandom);
                        b_bit     = 1'($urandom);
                        step();
                        chk("cnt_bubble", bit_cnt, acc);
                        chk("busy_bubble", busy, 1);
                        chk("done_bubble", done, 0);
                    end
                end
            end
        end
        bit_valid = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 0);
        chk("verdict", {aeb, agb, alb}, v);
        chk("cnt_at_done", bit_cnt, k);
        prev_v = v;
    endtask

    task automatic idle_step();
        start     = 1'b0;
        bit_valid = 1'b0;
        step();
        chk("done_cleared", done, 0);
        chk("busy_idle", busy, 0);
        chk("verdict_hold_idle", {aeb, agb, alb}, prev_v);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        prev_v    = 3'b000;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", bit_cnt, 0);
        chk("rst_verdict", {aeb, agb, alb}, 3'b000);

        // bit_valid in IDLE without start is ignored
        bit_valid = 1'b1;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_cnt", bit_cnt, 0);

        do_cmp(8'hA5, 8'hA5, 0, 0);
        idle_step();
        do_cmp(8'h80, 8'h7F, 0, 0);
        idle_step();
        do_cmp(8'h3C, 8'h3D, 3, 2);
        idle_step();

        // abort after 4 bits: no done from the partial comparison
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_bit     = 1'b1;
            b_bit     = 1'b0;
            bit_valid = 1'b1;
            step();
            chk("abort_no_done", done, 0);
            chk("abort_cnt", bit_cnt, i + 1);
        end
        do_cmp(8'h01, 8'h02, 0, 0);
        idle_step();

        // reset mid-comparison after 5 bits
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_bit     = 1'b0;
            b_bit     = 1'b0;
            bit_valid = 1'b1;
            step();
        end
        chk("pre_rst_cnt", bit_cnt, 5);
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        bit_valid = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", bit_cnt, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_verdict", {aeb, agb, alb}, 3'b000);
        prev_v = 3'b000;
        for (int i = 0; i < 3; i++)
            idle_step();

        // back-to-back: start lands in the DONE cycle
        do_cmp(8'h10, 8'h01, 0, 0);
        do_cmp(8'h01, 8'h10, 0, 0);
        idle_step();

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(3) == 0) ? ra : W'($urandom);
            do_cmp(ra, rb, $urandom_range(W - 1, 1), $urandom_range(3));
            if ($urandom_range(1) == 1)
                idle_step();
        end
        idle_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
